// File: rtl/led_sched.sv
// LED pattern scheduler: round-robin grant among three event sources, then a
// timed LED pattern (SHOW) followed by a blank gap (GAP) before re-arbitration.
module led_sched #(
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       clear,
  output logic [2:0] ack,
  output logic       busy,
  output logic [1:0] cur_src,
  output logic [1:0] led_out
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] ticks;
  logic [1:0]    last;
  logic          rst_hold;
  logic          tick;
  logic [1:0]    win;

  // Round-robin pick: search starts one past the last granted source.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] lst);
    logic [1:0] c;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    c     = (lst == 2'd2) ? 2'd0 : lst + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!found && r[c]) begin
        pick  = c;
        found = 1'b1;
      end
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
    end
  endfunction

  assign tick = (cnt == CNT_MAX);
  assign win  = pick(req, last);

  // Single FSM with all outputs registered; rst_hold suppresses a grant in the
  // first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      led_out  <= 2'b00;
      ack      <= 3'b000;
      busy     <= 1'b0;
      cur_src  <= 2'b11;
      cnt      <= '0;
      ticks    <= '0;
      last     <= 2'd2;
      rst_hold <= 1'b1;
    end else begin
      ack      <= 3'b000;
      rst_hold <= 1'b0;
      cnt      <= tick ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          if (!clear && !rst_hold && (req != 3'b000)) begin
            state   <= SHOW;
            ack     <= 3'b001 << win;
            cur_src <= win;
            busy    <= 1'b1;
            cnt     <= '0;
            ticks   <= '0;
            last    <= win;
            case (win)
              2'd0:    led_out <= 2'b11;
              2'd1:    led_out <= 2'b10;
              default: led_out <= 2'b01;
            endcase
          end
        end
        SHOW: begin
          if (clear) begin
            state   <= IDLE;
            led_out <= 2'b00;
            cur_src <= 2'b11;
            busy    <= 1'b0;
            cnt     <= '0;
            ticks   <= '0;
          end else if (tick) begin
            if (ticks == HOLD_LAST) begin
              state   <= GAP;
              cnt     <= '0;
              ticks   <= '0;
              led_out <= 2'b00;
              cur_src <= 2'b11;
            end else begin
              ticks <= ticks + HW'(1);
              // Only source 2 blinks; 01 and 10 are bitwise complements.
              if (cur_src == 2'd2) begin
                led_out <= ~led_out;
              end
            end
          end
        end
        GAP: begin
          if (clear || tick) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            led_out <= 2'b00;
            cur_src <= 2'b11;
          end
        end
        default: begin
          state   <= IDLE;
          led_out <= 2'b00;
          cur_src <= 2'b11;
          busy    <= 1'b0;
          cnt     <= '0;
          ticks   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_sched.sv
// Self-checking bench for led_sched: directed scenarios plus randomized
// stimulus compared every cycle against a cycle-age reference model.
module tb_led_sched;
  localparam int TD = 4;
  localparam int HT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [2:0] req;
  logic [2:0] ack;
  logic       busy;
  logic [1:0] cur_src;
  logic [1:0] led_out;

  int errors = 0;
  int checks = 0;

  led_sched #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk(clk), .reset(reset), .req(req), .clear(clear),
    .ack(ack), .busy(busy), .cur_src(cur_src), .led_out(led_out)
  );

  always #5 clk = ~clk;

  // Reference model: busy flag plus age in cycles since the grant.
  bit m_busy = 1'b0;
  bit m_hold = 1'b1;
  int m_age  = 0;
  int m_src  = 0;
  int m_last = 2;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_last = 2;
      m_hold = 1'b1;
    end else begin
      if (m_busy) begin
        if (clear) m_busy = 1'b0;
        else begin
          m_age++;
          if (m_age >= (HT + 1) * TD) m_busy = 1'b0;
        end
      end else if (!m_hold && !clear && req != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (req[(m_last + k) % 3]) begin
            m_src = (m_last + k) % 3;
            break;
          end
        end
        m_last = m_src;
        m_busy = 1'b1;
        m_age  = 0;
      end
      m_hold = 1'b0;
    end
  end

  function automatic logic [7:0] expect_outs();
    logic [2:0] a;
    logic       b;
    logic [1:0] c;
    logic [1:0] l;
    a = 3'b000; b = 1'b0; c = 2'b11; l = 2'b00;
    if (m_busy) begin
      b = 1'b1;
      if (m_age < HT * TD) begin
        c = 2'(m_src);
        if (m_age == 0) a = 3'(1 << m_src);
        case (m_src)
          0:       l = 2'b11;
          1:       l = 2'b10;
          default: l = (((m_age / TD) % 2) == 0) ? 2'b01 : 2'b10;
        endcase
      end
    end
    return {a, b, c, l};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs at a falling edge, step one clock, compare against the model.
  task automatic cyc(input logic [2:0] r, input logic c, input logic rs);
    req = r; clear = c; reset = rs;
    @(negedge clk);
    check("outs", {ack, busy, cur_src, led_out}, expect_outs());
  endtask

  task automatic do_reset();
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);
  endtask

  int         ack_t[$];
  logic [2:0] ack_v[$];
  logic [2:0] exp_order [4];

  initial begin
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;

    // Reset values, then fairness with req=111 held.
    cyc(3'b000, 1'b0, 1'b1);
    check("reset_vals", {ack, busy, cur_src, led_out}, {3'b000, 1'b0, 2'b11, 2'b00});
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      cyc(3'b111, 1'b0, 1'b0);
      if (ack != 3'b000) begin
        ack_t.push_back(i);
        ack_v.push_back(ack);
      end
      if (i == 1)  check("first_grant", {ack, cur_src, led_out, 1'b0}, {3'b001, 2'b00, 2'b11, 1'b0});
      if (i == 12) check("show_end_led", {6'd0, led_out}, {6'd0, 2'b11});
      if (i == 13) check("gap_start", {5'd0, busy, led_out}, {5'd0, 1'b1, 2'b00});
      if (i == 17) check("busy_fall", {7'd0, busy}, 8'd0);
    end
    check("ack_count", 8'(ack_t.size()), 8'd4);
    if (ack_t.size() >= 4) begin
      for (int k = 0; k < 4; k++) check("ack_order", {5'd0, ack_v[k]}, {5'd0, exp_order[k]});
      for (int k = 1; k < 4; k++) check("ack_spacing", 8'(ack_t[k] - ack_t[k-1]), 8'd17);
    end

    // Blink pattern for source 2.
    do_reset();
    cyc(3'b100, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) cyc(3'b000, 1'b0, 1'b0);
      check("blink", {6'd0, led_out},
            {6'd0, (i <= 4) ? 2'b01 : (i <= 8) ? 2'b10 : (i <= 12) ? 2'b01 : 2'b00});
    end

    // Clear on SHOW cycle 5, then immediate regrant of source 1.
    do_reset();
    cyc(3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b010, 1'b1, 1'b0);
    check("clear_idle", {ack, busy, cur_src, led_out}, {3'b000, 1'b0, 2'b11, 2'b00});
    cyc(3'b010, 1'b0, 1'b0);
    check("clear_regrant", {5'd0, ack}, {5'd0, 3'b010});

    // Clear beats req while idle.
    cyc(3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(3'b001, 1'b1, 1'b0);
      check("clear_blocks", {5'd0, ack}, 8'd0);
    end
    cyc(3'b001, 1'b0, 1'b0);
    check("grant_after_clear", {5'd0, ack}, {5'd0, 3'b001});

    // Reset in the middle of SHOW.
    for (int i = 0; i < 3; i++) cyc(3'b001, 1'b0, 1'b0);
    cyc(3'b001, 1'b0, 1'b1);
    check("mid_reset", {ack, busy, cur_src, led_out}, {3'b000, 1'b0, 2'b11, 2'b00});
    cyc(3'b001, 1'b0, 1'b0);
    check("no_ack_after_reset", {5'd0, ack}, 8'd0);
    cyc(3'b001, 1'b0, 1'b0);
    check("ack_two_after_reset", {5'd0, ack}, {5'd0, 3'b001});

    // Randomized traffic.
    begin
      logic [2:0] r;
      r = 3'b000;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) r = 3'($urandom_range(0, 7));
        cyc(r, ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_sched.md
LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clock cycles per display tick (legal range 2 or more).
REQ-002 Parameter HOLD_TICKS, default 4, number of ticks a granted pattern is displayed (legal range 1 or more).
REQ-003 Port clk, input, 1, single system clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port req, input, 3, level requests from three event sources, index = source id.
REQ-006 Port clear, input, 1, synchronous abort of the pattern currently shown.
REQ-007 Port ack, output, 3, one-hot single-cycle grant pulse to the winning source.
REQ-008 Port busy, output, 1, high while state is SHOW or GAP.
REQ-009 Port cur_src, output, 2, id of the source being shown; 2'b11 when none.
REQ-010 Port led_out, output, 2, LED code to the LED decoder: 00 off, 01 all-on, 10 centre-only, 11 dark-alt.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHOW and GAP, and all outputs SHALL be registered.
REQ-012 Tick counter: counts 0..TICK_DIV-1 and wraps; tick is asserted in the cycle the counter equals TICK_DIV-1; counter is cleared on grant and on entry to GAP.
REQ-013 IDLE: led_out=00, busy=0, cur_src=11; if any req bit is 1 and clear=0 at a clock edge, the block SHALL grant exactly one source.
REQ-014 Arbitration: round-robin; search order starts at (last_granted+1) mod 3; last_granted updates on every grant.
REQ-015 Grant: the next cycle has state=SHOW, ack[winner]=1 for exactly that cycle, cur_src=winner, busy=1, and the tick count cleared.
REQ-016 req is sampled only in IDLE; requests in SHOW/GAP are neither acked nor queued; sources hold req until ack.
REQ-017 SHOW pattern, source 2: led_out alternates 01,10,01,... starting 01 on the grant cycle and toggling on every tick.
REQ-018 SHOW pattern, source 1: steady 10; source 0: steady 11.
REQ-019 SHOW lasts exactly HOLD_TICKS*TICK_DIV cycles; on the tick that completes HOLD_TICKS ticks, the next state SHALL be GAP.
REQ-020 GAP: led_out=00, cur_src=11, busy=1; lasts exactly TICK_DIV cycles, then the block returns to IDLE.
REQ-021 Minimum spacing between consecutive ack pulses SHALL be (HOLD_TICKS+1)*TICK_DIV+1 cycles.
REQ-022 clear=1 in SHOW or GAP: next cycle state=IDLE, led_out=00, cur_src=11, busy=0, tick counter=0; last_granted is kept.
REQ-023 clear=1 in IDLE blocks any grant in that cycle (clear beats req).
REQ-024 A deasserted req during SHOW SHALL NOT shorten the pattern.
REQ-025 The tick-count register SHALL be sized to hold HOLD_TICKS, and its comparison SHALL be exact with no overflow.

Reset
REQ-026 reset=1 SHALL override all inputs, including clear and req.
REQ-027 Reset values: state=IDLE, led_out=00, ack=000, busy=0, cur_src=11, tick counter=0, last_granted=2 (so req[0] has first priority).
REQ-028 Reset asserted mid-SHOW SHALL take effect at the next edge, and no ack SHALL be issued in the cycle after reset deasserts.

Verification (TICK_DIV=4, HOLD_TICKS=3)
REQ-029 Reset check: after reset, drive req=111 -> ack=001 one cycle later, cur_src=00, led_out=11 for 12 cycles, then 00 for 4 cycles, busy falls at cycle 17.
REQ-030 Fairness check: hold req=111 continuously -> ack order 001,010,100,001, with consecutive acks spaced 17 cycles apart.
REQ-031 Blink check: req=100 only -> led_out sequence 01 (4 cycles), 10 (4), 01 (4), then 00 (4).
REQ-032 Clear check: clear=1 on cycle 5 of SHOW -> next cycle busy=0, led_out=00; with req=010 held, ack=010 one cycle after clear drops.
REQ-033 Simultaneous check: clear=1 and req=001 in IDLE -> no ack; a grant happens only in the first cycle with clear=0.
REQ-034 Mid-pattern reset check: reset during SHOW -> next cycle all outputs at reset values; with req=001 held, ack=001 two cycles after reset falls.
